pack_fifo: RTL and testbench

Width up-converting FIFO, the write-side counterpart of the team's down-converting FIFO. Accepts narrow input words (default 8-bit) and packs them LSB-lane-first into wide words (default 64-bit). Buffers up to Depth wide words. Wide words are read one per accepted read. Sits where a narrow byte stream (pixel/weight bytes) must be gathered into wide words for storage or bus transfer.

---
 rtl/pack_fifo_pkg.sv | 21 ++
 rtl/pack_fifo_if.sv | 26 ++
 rtl/pack_fifo_lane_packer.sv | 62 ++++++
 rtl/pack_fifo.sv | 105 ++++++++++
 tb/tb_pack_fifo.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pack_fifo_pkg.sv
// Shared helpers for the width up-converting FIFO: index/count widths and
// the legality check on the narrow/wide width pair.
package pack_fifo_pkg;

   function automatic int laneWidth(input int ratio);
      return (ratio > 2) ? $clog2(ratio) : 1;
   endfunction

   function automatic int addrWidth(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int countWidth(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit widthsOk(input int inWidth, input int outWidth);
      return (inWidth > 0) && (outWidth % inWidth == 0) && (outWidth / inWidth >= 2);
   endfunction

endpackage

// File: rtl/pack_fifo_if.sv
// Handshake/data bundle of the packing FIFO; master is the user side,
// slave is the FIFO side.
interface pack_fifo_if #(
   parameter int InputWidth  = 8,
   parameter int OutputWidth = 64
);
   logic                   write_en_i;
   logic [InputWidth-1:0]  data_i;
   logic                   flush_i;
   logic                   read_en_i;
   logic [OutputWidth-1:0] data_o;
   logic                   valid_o;
   logic                   full_o;
   logic                   empty_o;
   logic                   partial_o;

   modport master (
      output write_en_i, data_i, flush_i, read_en_i,
      input  data_o, valid_o, full_o, empty_o, partial_o
   );

   modport slave (
      input  write_en_i, data_i, flush_i, read_en_i,
      output data_o, valid_o, full_o, empty_o, partial_o
   );
endinterface

// File: rtl/pack_fifo_lane_packer.sv
// Gathers narrow words into one wide word, lane 0 in the LSBs, and raises a
// same-cycle commit strobe when the word completes or is flushed.
module pack_fifo_lane_packer
   import pack_fifo_pkg::*;
#(
   parameter int InputWidth  = 8,
   parameter int OutputWidth = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   write_i,
   input  logic [InputWidth-1:0]  data_i,
   input  logic                   flush_i,
   output logic                   commit_o,
   output logic [OutputWidth-1:0] word_o,
   output logic                   partial_o
);
   localparam int Ratio     = OutputWidth / InputWidth;
   localparam int LaneWidth = laneWidth(Ratio);

   logic [LaneWidth-1:0]   lane_q, lane_d;
   logic [OutputWidth-1:0] acc_q, acc_d, merged;
   logic                   lastLane;

   // The word presented on commit already contains this cycle's narrow write.
   always_comb begin
      merged = acc_q;
      for (int k = 0; k < Ratio; k++) begin
         if (write_i && (lane_q == LaneWidth'(k))) begin
            merged[k*InputWidth +: InputWidth] = data_i;
         end
      end
   end

   assign lastLane  = (lane_q == LaneWidth'(Ratio - 1));
   assign commit_o  = (write_i && lastLane) || (flush_i && ((lane_q != '0) || write_i));
   assign word_o    = merged;
   assign partial_o = (lane_q != '0);

   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      if (commit_o) begin
         lane_d = '0;
         acc_d  = '0;
      end else if (write_i) begin
         lane_d = lane_q + LaneWidth'(1);
         acc_d  = merged;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
         acc_q  <= '0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/pack_fifo.sv
// Width up-converting FIFO: narrow writes are packed into wide words, held in a
// Depth-entry ring buffer and returned one wide word per accepted read.
module pack_fifo
   import pack_fifo_pkg::*;
#(
   parameter int InputWidth  = 8,
   parameter int OutputWidth = 64,
   parameter int Depth       = 16
) (
   input logic        clk_i,
   input logic        rst_ni,
   pack_fifo_if.slave bus
);
   localparam int AddrWidth  = addrWidth(Depth);
   localparam int CountWidth = countWidth(Depth);

   if (!widthsOk(InputWidth, OutputWidth)) begin : gBadWidths
      $error("pack_fifo: OutputWidth must be a multiple of InputWidth with ratio >= 2");
   end
   if (Depth < 2) begin : gBadDepth
      $error("pack_fifo: Depth must be at least 2");
   end

   logic [OutputWidth-1:0] store_q [Depth];
   logic [AddrWidth-1:0]   writePtr_q, writePtr_d, readPtr_q, readPtr_d;
   logic [CountWidth-1:0]  count_q, count_d;
   logic [OutputWidth-1:0] data_q, data_d, packedWord;
   logic                   valid_q, valid_d;
   logic                   full, empty, writeAccept, flushAccept, readAccept;
   logic                   commit, partial;

   assign full        = (count_q == CountWidth'(Depth));
   assign empty       = (count_q == '0);
   assign writeAccept = bus.write_en_i && !full;
   assign flushAccept = bus.flush_i && !full;
   assign readAccept  = bus.read_en_i && !empty;

   pack_fifo_lane_packer #(
      .InputWidth (InputWidth),
      .OutputWidth(OutputWidth)
   ) uPacker (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .write_i  (writeAccept),
      .data_i   (bus.data_i),
      .flush_i  (flushAccept),
      .commit_o (commit),
      .word_o   (packedWord),
      .partial_o(partial)
   );

   // Explicit wrap so non-power-of-two depths never index past the last slot.
   function automatic logic [AddrWidth-1:0] nextPtr(input logic [AddrWidth-1:0] ptr);
      return (ptr == AddrWidth'(Depth - 1)) ? '0 : ptr + AddrWidth'(1);
   endfunction

   always_comb begin
      writePtr_d = writePtr_q;
      readPtr_d  = readPtr_q;
      count_d    = count_q;
      data_d     = data_q;
      valid_d    = readAccept;
      if (commit) begin
         writePtr_d = nextPtr(writePtr_q);
      end
      if (readAccept) begin
         readPtr_d = nextPtr(readPtr_q);
         data_d    = store_q[readPtr_q];
      end
      case ({commit, readAccept})
         2'b10:   count_d = count_q + CountWidth'(1);
         2'b01:   count_d = count_q - CountWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (commit) begin
         store_q[writePtr_q] <= packedWord;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         writePtr_q <= '0;
         readPtr_q  <= '0;
         count_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         writePtr_q <= writePtr_d;
         readPtr_q  <= readPtr_d;
         count_q    <= count_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.data_o    = data_q;
   assign bus.valid_o   = valid_q;
   assign bus.full_o    = full;
   assign bus.empty_o   = empty;
   assign bus.partial_o = partial;

endmodule

// File: tb/tb_pack_fifo.sv
// Drives a Depth=16 and a Depth=5 pack_fifo with identical stimulus and checks
// both against a byte-queue / committed-word-log model every cycle.
module tb_pack_fifo;
   localparam int IW    = 8;
   localparam int OW    = 64;
   localparam int R     = OW / IW;
   localparam int D0    = 16;
   localparam int D1    = 5;
   localparam int HistN = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          weIn = 1'b0;
   logic [IW-1:0] dIn = '0;
   logic          flIn = 1'b0;
   logic          reIn = 1'b0;

   pack_fifo_if #(.InputWidth(IW), .OutputWidth(OW)) bus0 ();
   pack_fifo_if #(.InputWidth(IW), .OutputWidth(OW)) bus1 ();

   assign bus0.write_en_i = weIn;
   assign bus0.data_i     = dIn;
   assign bus0.flush_i    = flIn;
   assign bus0.read_en_i  = reIn;
   assign bus1.write_en_i = weIn;
   assign bus1.data_i     = dIn;
   assign bus1.flush_i    = flIn;
   assign bus1.read_en_i  = reIn;

   pack_fifo #(.InputWidth(IW), .OutputWidth(OW), .Depth(D0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
   );
   pack_fifo #(.InputWidth(IW), .OutputWidth(OW), .Depth(D1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus1)
   );

   logic [OW-1:0] dutData [2];
   logic          dutValid [2];
   logic          dutFull [2];
   logic          dutEmpty [2];
   logic          dutPartial [2];
   assign dutData[0] = bus0.data_o;    assign dutData[1] = bus1.data_o;
   assign dutValid[0] = bus0.valid_o;  assign dutValid[1] = bus1.valid_o;
   assign dutFull[0] = bus0.full_o;    assign dutFull[1] = bus1.full_o;
   assign dutEmpty[0] = bus0.empty_o;  assign dutEmpty[1] = bus1.empty_o;
   assign dutPartial[0] = bus0.partial_o; assign dutPartial[1] = bus1.partial_o;

   // Model: pending narrow bytes plus a log of every committed wide word.
   logic [IW-1:0] pend [2][R];
   int            nPend [2];
   logic [OW-1:0] hist [2][HistN];
   int            pushed [2];
   int            popped [2];
   logic [OW-1:0] expData [2];
   logic          expValid [2];

   int tests = 0;
   int fails = 0;

   function automatic int depthOf(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         nPend[i] = 0; pushed[i] = 0; popped[i] = 0;
         expData[i] = '0; expValid[i] = 1'b0;
      end
   endtask

   task automatic modelUpdate();
      for (int i = 0; i < 2; i++) begin
         int cnt;
         bit isFull, isEmpty, wAcc, rAcc, doCommit;
         logic [OW-1:0] word;
         cnt     = pushed[i] - popped[i];
         isFull  = (cnt == depthOf(i));
         isEmpty = (cnt == 0);
         wAcc    = weIn && !isFull;
         rAcc    = reIn && !isEmpty;
         if (wAcc) begin
            pend[i][nPend[i]] = dIn;
            nPend[i]++;
         end
         doCommit = (nPend[i] == R) || (flIn && !isFull && nPend[i] != 0);
         expValid[i] = rAcc;
         if (rAcc) begin
            expData[i] = hist[i][popped[i]];
            popped[i]++;
         end
         if (doCommit) begin
            word = '0;
            for (int k = 0; k < nPend[i]; k++) word = word | (OW'(pend[i][k]) << (IW * k));
            hist[i][pushed[i]] = word;
            pushed[i]++;
            nPend[i] = 0;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compareAll();
      for (int i = 0; i < 2; i++) begin
         int cnt;
         cnt = pushed[i] - popped[i];
         checkOutput($sformatf("dut%0d_data", i), 72'(dutData[i]), 72'(expData[i]));
         checkOutput($sformatf("dut%0d_flags(v,f,e,p)", i),
                     72'({dutValid[i], dutFull[i], dutEmpty[i], dutPartial[i]}),
                     72'({expValid[i], cnt == depthOf(i), cnt == 0, nPend[i] != 0}));
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [IW-1:0] d, input bit fl, input bit re);
      weIn = we; dIn = d; flIn = fl; reIn = re;
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      compareAll();
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic resetDut();
      weIn = 1'b0; flIn = 1'b0; reIn = 1'b0;
      #1 rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      compareAll();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [OW-1:0] lastRead;
      modelReset();
      repeat (2) @(negedge clk);
      compareAll();
      checkOutput("reset_empty", 72'(dutEmpty[0]), 72'd1);
      checkOutput("reset_full", 72'(dutFull[0]), 72'd0);
      checkOutput("reset_data", 72'(dutData[0]), 72'd0);
      #1 rst_n = 1'b1;

      // Eight bytes make one word; empty drops only after the eighth.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, IW'(i), 1'b0, 1'b0);
         if (i == 7) checkOutput("t1_empty_before_8th", 72'(dutEmpty[0]), 72'd1);
      end
      checkOutput("t1_empty_after_8th", 72'(dutEmpty[0]), 72'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t1_read_data", 72'(dutData[0]), 72'h0807060504030201);
      checkOutput("t1_read_data_d5", 72'(dutData[1]), 72'h0807060504030201);
      checkOutput("t1_valid", 72'(dutValid[0]), 72'd1);
      idle();
      checkOutput("t1_valid_drop", 72'(dutValid[0]), 72'd0);
      checkOutput("t1_empty_again", 72'(dutEmpty[0]), 72'd1);

      // Fill to Depth, refuse one more byte, then drain.
      resetDut();
      for (int i = 0; i < 128; i++) applyStimulus(1'b1, IW'(i), 1'b0, 1'b0);
      checkOutput("t2_full", 72'(dutFull[0]), 72'd1);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      checkOutput("t2_full_hold", 72'(dutFull[0]), 72'd1);
      checkOutput("t2_no_partial", 72'(dutPartial[0]), 72'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t2_not_full", 72'(dutFull[0]), 72'd0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      lastRead = dutData[0];
      checkOutput("t2_last_word", 72'(lastRead), 72'h7F7E7D7C7B7A7978);
      checkOutput("t2_empty", 72'(dutEmpty[0]), 72'd1);

      // Partial word flushed with zero padding; flush at lane 0 is a no-op.
      resetDut();
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      checkOutput("t3_partial", 72'(dutPartial[0]), 72'd1);
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t3_partial_clear", 72'(dutPartial[0]), 72'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t3_flush_data", 72'(dutData[0]), 72'h0000000000CCBBAA);
      idle();
      checkOutput("t3_empty_after", 72'(dutEmpty[0]), 72'd1);
      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t3_write_flush", 72'(dutData[0]), 72'h000000000000005A);

      // Commit and read on the same edge keep the count at five.
      resetDut();
      for (int i = 0; i < 47; i++) applyStimulus(1'b1, IW'(8'h10 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, IW'(8'h10 + 47), 1'b0, 1'b1);
      checkOutput("t4_oldest", 72'(dutData[0]), 72'h1716151413121110);
      checkOutput("t4_not_empty", 72'(dutEmpty[0]), 72'd0);
      checkOutput("t4_not_full", 72'(dutFull[0]), 72'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t4_one_left", 72'(dutEmpty[0]), 72'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t4_drained", 72'(dutEmpty[0]), 72'd1);
      checkOutput("t4_sixth_word", 72'(dutData[0]), 72'h3F3E3D3C3B3A3938);

      // Random streaming across many pointer wraps in both depths.
      resetDut();
      for (int c = 0; c < 520; c++) begin
         applyStimulus($urandom_range(99) < 75, IW'($urandom), $urandom_range(31) == 0,
                       $urandom_range(99) < 55);
      end
      for (int c = 0; c < 40; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t5_words_dut0", 72'(pushed[0] >= 40), 72'd1);

      // Asynchronous reset mid-cycle discards everything immediately.
      resetDut();
      for (int i = 0; i < 29; i++) applyStimulus(1'b1, IW'(8'h80 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t6_pre_partial", 72'(dutPartial[0]), 72'd1);
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("t6_rst_data", 72'(dutData[0]), 72'd0);
      checkOutput("t6_rst_flags(v,f,e,p)",
                  72'({dutValid[0], dutFull[0], dutEmpty[0], dutPartial[0]}), 72'b0010);
      @(negedge clk);
      compareAll();
      #1 rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, IW'(8'h30 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t6_clean_word", 72'(dutData[0]), 72'h3837363534333231);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
